sdram_cmd_sched: RTL and testbench

SDRAM_CMD_SCHED -- requirements
Module: sdram_cmd_sched

---
 rtl/sdram_pkg.sv | 45 ++++
 rtl/sdram_cmd_sched.sv | 249 ++++++++++++++++++++++++
 tb/tb_sdram_cmd_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs,ras,cas,we}, scheduler states
// and the mode-register field layout used during initialisation.
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_MRS   = 4'b0000,
        CMD_REF   = 4'b0001,
        CMD_PRE   = 4'b0010,
        CMD_ACT   = 4'b0011,
        CMD_WRITE = 4'b0100,
        CMD_READ  = 4'b0101,
        CMD_NOP   = 4'b0111
    } sdram_cmd_e;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_REF,
        ST_INIT_MRS,
        ST_IDLE,
        ST_REFRESH,
        ST_ACT,
        ST_RW,
        ST_RECOVER
    } sched_state_e;

    localparam int unsigned INIT_REF_COUNT = 8;
    localparam int unsigned MRS_SETTLE     = 2;
    localparam int unsigned A10_BIT        = 10;

    // Mode register: [2:0] burst length code, [3] burst type (0 = sequential), [6:4] CAS latency
    localparam int unsigned MRS_BL_LSB = 0;
    localparam int unsigned MRS_BT_BIT = 3;
    localparam int unsigned MRS_CL_LSB = 4;

    function automatic logic [15:0] mrs_word(input int unsigned bl_code, input int unsigned cas_lat);
        logic [15:0] w;
        w = '0;
        w[MRS_BL_LSB +: 3] = 3'(bl_code);
        w[MRS_BT_BIT]      = 1'b0;
        w[MRS_CL_LSB +: 3] = 3'(cas_lat);
        return w;
    endfunction

endpackage

// File: rtl/sdram_cmd_sched.sv
// SDRAM command scheduler: power-up init, periodic refresh and single-burst read/write arbitration.
// Define SDRAM_SCHED_RR_EN for round-robin arbitration; otherwise writes have fixed priority.
module sdram_cmd_sched
    import sdram_pkg::*;
#(
    parameter int unsigned BANK_WIDTH       = 2,
    parameter int unsigned ROW_WIDTH        = 13,
    parameter int unsigned COL_WIDTH        = 9,
    parameter int unsigned BURST_POW_SIZE   = 3,
    parameter int unsigned POWERUP_CYCLES   = 20000,
    parameter int unsigned REFRESH_INTERVAL = 780,
    parameter int unsigned tRCD             = 2,
    parameter int unsigned tRP              = 2,
    parameter int unsigned tRC              = 7,
    parameter int unsigned CAS_LAT          = 2
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_wr_req,
    input  logic [BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] i_wr_addr,
    output logic                                    o_wr_ack,
    output logic                                    o_wr_data_en,
    input  logic                                    i_rd_req,
    input  logic [BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] i_rd_addr,
    output logic                                    o_rd_ack,
    output logic                                    o_rd_valid,
    output logic                                    o_init_done,
    output logic [3:0]                              o_cmd,
    output logic [BANK_WIDTH-1:0]                   o_ba,
    output logic [ROW_WIDTH-1:0]                    o_addr,
    output logic                                    o_cke
);

    localparam int unsigned ADDR_W     = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
    localparam int unsigned BURST_SIZE = 2 ** BURST_POW_SIZE;
    localparam int unsigned WR_RECOVER = BURST_SIZE + tRP;
    localparam int unsigned RD_RECOVER = BURST_SIZE + CAS_LAT + tRP;
    localparam int unsigned CNT_MAX    = (POWERUP_CYCLES > RD_RECOVER + tRC) ? POWERUP_CYCLES
                                                                            : RD_RECOVER + tRC;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned REF_CNT_W  = $clog2(INIT_REF_COUNT);
    localparam int unsigned TMR_W      = $clog2(REFRESH_INTERVAL + 1);

    sched_state_e           state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [REF_CNT_W-1:0]   ref_cnt, ref_cnt_d;
    logic                   op_wr, op_wr_d;
    logic [ADDR_W-1:0]      op_addr, op_addr_d;
    logic [TMR_W-1:0]       ref_timer;
    logic                   refresh_pending;
    logic                   ref_issue;
    logic                   grant_wr, grant_rd;

    sdram_cmd_e             cmd_d;
    logic [BANK_WIDTH-1:0]  ba_d;
    logic [ROW_WIDTH-1:0]   a_d;
    logic                   init_done_d;
    logic                   wr_ack_d, rd_ack_d, wr_en_d, rd_valid_d;

`ifdef SDRAM_SCHED_RR_EN
    logic last_wr, last_wr_d;

    // The requester not served last wins a tie; reset state favours write first.
    assign grant_wr = i_wr_req && (!i_rd_req || !last_wr);
`else
    assign grant_wr = i_wr_req;
`endif
    assign grant_rd = i_rd_req && !grant_wr;

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt + 1'b1;
        ref_cnt_d   = ref_cnt;
        op_wr_d     = op_wr;
        op_addr_d   = op_addr;
        cmd_d       = CMD_NOP;
        ba_d        = '0;
        a_d         = '0;
        init_done_d = o_init_done;
        wr_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        wr_en_d     = 1'b0;
        rd_valid_d  = 1'b0;
        ref_issue   = 1'b0;
`ifdef SDRAM_SCHED_RR_EN
        last_wr_d   = last_wr;
`endif
        case (state)
            ST_INIT_WAIT: begin
                if (cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
                    state_d = ST_INIT_PRE;
                    cnt_d   = '0;
                end
            end
            ST_INIT_PRE: begin
                if (cnt == '0) begin
                    cmd_d         = CMD_PRE;
                    a_d[A10_BIT]  = 1'b1;
                end
                if (cnt == CNT_W'(tRP)) begin
                    state_d = ST_INIT_REF;
                    cnt_d   = '0;
                end
            end
            ST_INIT_REF: begin
                if (cnt == '0) cmd_d = CMD_REF;
                if (cnt == CNT_W'(tRC)) begin
                    cnt_d = '0;
                    if (ref_cnt == REF_CNT_W'(INIT_REF_COUNT - 1)) begin
                        state_d   = ST_INIT_MRS;
                        ref_cnt_d = '0;
                    end else begin
                        ref_cnt_d = ref_cnt + 1'b1;
                    end
                end
            end
            ST_INIT_MRS: begin
                if (cnt == '0) begin
                    cmd_d = CMD_MRS;
                    a_d   = ROW_WIDTH'(mrs_word(BURST_POW_SIZE, CAS_LAT));
                end
                if (cnt == CNT_W'(MRS_SETTLE)) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (refresh_pending) begin
                    state_d = ST_REFRESH;
                end else if (grant_wr || grant_rd) begin
                    state_d   = ST_ACT;
                    op_wr_d   = grant_wr;
                    op_addr_d = grant_wr ? i_wr_addr : i_rd_addr;
`ifdef SDRAM_SCHED_RR_EN
                    last_wr_d = grant_wr;
`endif
                end
            end
            ST_REFRESH: begin
                if (cnt == '0) begin
                    cmd_d     = CMD_REF;
                    ref_issue = 1'b1;
                end
                if (cnt == CNT_W'(tRC)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_ACT: begin
                if (cnt == '0) begin
                    cmd_d = CMD_ACT;
                    ba_d  = op_addr[ADDR_W-1 -: BANK_WIDTH];
                    a_d   = op_addr[COL_WIDTH +: ROW_WIDTH];
                end
                if (cnt == CNT_W'(tRCD)) begin
                    state_d = ST_RW;
                    cnt_d   = '0;
                end
            end
            ST_RW: begin
                cmd_d                  = op_wr ? CMD_WRITE : CMD_READ;
                ba_d                   = op_addr[ADDR_W-1 -: BANK_WIDTH];
                a_d[COL_WIDTH-1:0]     = op_addr[COL_WIDTH-1:0];
                a_d[A10_BIT]           = 1'b1;
                wr_ack_d               = op_wr;
                rd_ack_d               = !op_wr;
                wr_en_d                = op_wr;
                state_d                = ST_RECOVER;
                cnt_d                  = '0;
            end
            ST_RECOVER: begin
                // Count 0 lines up with the cycle after the READ/WRITE command.
                wr_en_d    = op_wr && (cnt < CNT_W'(BURST_SIZE - 1));
                rd_valid_d = !op_wr && (cnt >= CNT_W'(CAS_LAT - 1))
                                    && (cnt < CNT_W'(CAS_LAT + BURST_SIZE - 1));
                if ((op_wr && cnt == CNT_W'(WR_RECOVER - 1)) ||
                    (!op_wr && cnt == CNT_W'(RD_RECOVER - 1))) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters, latched request and registered SDRAM outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_INIT_WAIT;
            cnt          <= '0;
            ref_cnt      <= '0;
            op_wr        <= 1'b0;
            op_addr      <= '0;
            o_cmd        <= CMD_NOP;
            o_ba         <= '0;
            o_addr       <= '0;
            o_cke        <= 1'b1;
            o_init_done  <= 1'b0;
            o_wr_ack     <= 1'b0;
            o_rd_ack     <= 1'b0;
            o_wr_data_en <= 1'b0;
            o_rd_valid   <= 1'b0;
`ifdef SDRAM_SCHED_RR_EN
            last_wr      <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            ref_cnt      <= ref_cnt_d;
            op_wr        <= op_wr_d;
            op_addr      <= op_addr_d;
            o_cmd        <= cmd_d;
            o_ba         <= ba_d;
            o_addr       <= a_d;
            o_cke        <= 1'b1;
            o_init_done  <= init_done_d;
            o_wr_ack     <= wr_ack_d;
            o_rd_ack     <= rd_ack_d;
            o_wr_data_en <= wr_en_d;
            o_rd_valid   <= rd_valid_d;
`ifdef SDRAM_SCHED_RR_EN
            last_wr      <= last_wr_d;
`endif
        end
    end

    // Refresh timer runs only after init; an expiry wins over a same-cycle REF issue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ref_timer       <= '0;
            refresh_pending <= 1'b0;
        end else if (!o_init_done) begin
            ref_timer <= TMR_W'(REFRESH_INTERVAL - 1);
        end else if (ref_timer == '0) begin
            ref_timer       <= TMR_W'(REFRESH_INTERVAL - 1);
            refresh_pending <= 1'b1;
        end else begin
            ref_timer <= ref_timer - 1'b1;
            if (ref_issue) refresh_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Directed bench for sdram_cmd_sched: init sequence, single bursts, arbitration,
// refresh deferral and mid-burst reset. Honours SDRAM_SCHED_RR_EN for arbitration order.
module tb_sdram_cmd_sched;
    import sdram_pkg::*;

    localparam int unsigned PWRUP   = 100;
    localparam int unsigned REF_INT = 200;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_wr_req, i_rd_req;
    logic [23:0] i_wr_addr, i_rd_addr;
    logic        o_wr_ack, o_wr_data_en, o_rd_ack, o_rd_valid, o_init_done, o_cke;
    logic [3:0]  o_cmd;
    logic [1:0]  o_ba;
    logic [12:0] o_addr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t, n, first, p, e_cyc;

    sdram_cmd_sched #(
        .POWERUP_CYCLES   (PWRUP),
        .REFRESH_INTERVAL (REF_INT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr_req     (i_wr_req),
        .i_wr_addr    (i_wr_addr),
        .o_wr_ack     (o_wr_ack),
        .o_wr_data_en (o_wr_data_en),
        .i_rd_req     (i_rd_req),
        .i_rd_addr    (i_rd_addr),
        .o_rd_ack     (o_rd_ack),
        .o_rd_valid   (o_rd_valid),
        .o_init_done  (o_init_done),
        .o_cmd        (o_cmd),
        .o_ba         (o_ba),
        .o_addr       (o_addr),
        .o_cke        (o_cke)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Advance to the next non-NOP command; an expired budget leaves NOP for the caller to flag.
    task automatic wait_cmd(input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (o_cmd == CMD_NOP && k < budget);
    endtask

    task automatic check_init();
        int nops, last;
        nops = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (o_cmd != CMD_NOP) break;
            nops++;
        end
        check("init_nops", 32'(nops), 32'(PWRUP));
        check("init_pre", 32'(o_cmd), 32'(CMD_PRE));
        check("init_pre_a10", 32'(o_addr[10]), 32'd1);
        last = cyc;
        for (int r = 0; r < 8; r++) begin
            wait_cmd(20);
            check("init_ref", 32'(o_cmd), 32'(CMD_REF));
            check("init_ref_gap", 32'(cyc - last), (r == 0) ? 32'd3 : 32'd8);
            last = cyc;
        end
        wait_cmd(20);
        check("init_mrs", 32'(o_cmd), 32'(CMD_MRS));
        check("init_mrs_a", 32'(o_addr), 32'h023);
        check("init_mrs_gap", 32'(cyc - last), 32'd8);
        check("init_done_early", 32'(o_init_done), 32'd0);
        step();
        step();
        check("init_done", 32'(o_init_done), 32'd1);
        e_cyc = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_wr_req = 1'b0;
        i_rd_req = 1'b0;
        i_wr_addr = '0;
        i_rd_addr = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_cmd", 32'(o_cmd), 32'(CMD_NOP));
        check("rst_cke", 32'(o_cke), 32'd1);
        check("rst_init_done", 32'(o_init_done), 32'd0);
        check("rst_bus", 32'({o_ba, o_addr}), 32'd0);
        check("rst_flags", 32'({o_wr_ack, o_rd_ack, o_wr_data_en, o_rd_valid}), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        check_init();

        // Single write: bank 1, row 0x0A5, col 0x010
        i_wr_addr = {2'd1, 13'h0A5, 9'h010};
        i_wr_req = 1'b1;
        wait_cmd(50);
        check("wr_act", 32'(o_cmd), 32'(CMD_ACT));
        check("wr_act_ba", 32'(o_ba), 32'd1);
        check("wr_act_row", 32'(o_addr), 32'h0A5);
        t = cyc;
        wait_cmd(20);
        check("wr_cmd", 32'(o_cmd), 32'(CMD_WRITE));
        check("wr_gap", 32'(cyc - t), 32'd3);
        check("wr_a", 32'(o_addr), 32'h410);
        check("wr_ba", 32'(o_ba), 32'd1);
        check("wr_ack", 32'(o_wr_ack), 32'd1);
        check("wr_en_start", 32'(o_wr_data_en), 32'd1);
        i_wr_req = 1'b0;
        n = 1;
        step();
        check("wr_ack_pulse", 32'(o_wr_ack), 32'd0);
        for (int k = 0; k < 20; k++) begin
            if (!o_wr_data_en) break;
            n++;
            step();
        end
        check("wr_en_len", 32'(n), 32'd8);

        // Single read at the same address
        i_rd_addr = {2'd1, 13'h0A5, 9'h010};
        i_rd_req = 1'b1;
        wait_cmd(50);
        check("rd_act", 32'(o_cmd), 32'(CMD_ACT));
        wait_cmd(20);
        check("rd_cmd", 32'(o_cmd), 32'(CMD_READ));
        check("rd_a", 32'(o_addr), 32'h410);
        check("rd_ack", 32'(o_rd_ack), 32'd1);
        check("rd_valid_early", 32'(o_rd_valid), 32'd0);
        i_rd_req = 1'b0;
        t = cyc;
        first = -1;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (o_rd_valid) begin
                if (n == 0) first = cyc;
                n++;
            end
        end
        check("rd_valid_lat", 32'(first - t), 32'd2);
        check("rd_valid_len", 32'(n), 32'd8);

        // Both requesters held: observe three grants
        i_wr_req = 1'b1;
        i_rd_req = 1'b1;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 6; k++) begin
                wait_cmd(60);
                if (o_cmd == CMD_WRITE || o_cmd == CMD_READ) break;
            end
`ifdef SDRAM_SCHED_RR_EN
            check("arb_order", 32'(o_cmd), (g == 1) ? 32'(CMD_READ) : 32'(CMD_WRITE));
`else
            check("arb_order", 32'(o_cmd), 32'(CMD_WRITE));
`endif
        end
        i_wr_req = 1'b0;
        i_rd_req = 1'b0;
        repeat (20) step();

        // Refresh expiry lands inside a write burst
        p = e_cyc + REF_INT;
        while (p < cyc + 12) p += REF_INT;
        while (cyc < p - 8) step();
        i_wr_addr = {2'd2, 13'h111, 9'h020};
        i_rd_addr = {2'd3, 13'h0F0, 9'h008};
        i_wr_req = 1'b1;
        wait_cmd(30);
        check("ref_wr_act", 32'(o_cmd), 32'(CMD_ACT));
        wait_cmd(20);
        check("ref_wr_cmd", 32'(o_cmd), 32'(CMD_WRITE));
        check("ref_wr_cyc", 32'(cyc), 32'(p - 3));
        i_wr_req = 1'b0;
        i_rd_req = 1'b1;
        t = cyc;
        wait_cmd(40);
        check("ref_cmd", 32'(o_cmd), 32'(CMD_REF));
        check("ref_gap", 32'(cyc - t), 32'd12);
        t = cyc;
        wait_cmd(40);
        check("ref_rd_act", 32'(o_cmd), 32'(CMD_ACT));
        check("ref_rd_gap", 32'(cyc - t), 32'd9);
        check("ref_rd_ba", 32'(o_ba), 32'd3);
        wait_cmd(20);
        check("ref_rd_cmd", 32'(o_cmd), 32'(CMD_READ));
        i_rd_req = 1'b0;
        repeat (20) step();

        // Reset mid-burst: write stays requested across the rerun of init
        i_wr_addr = {2'd1, 13'h0A5, 9'h010};
        i_wr_req = 1'b1;
        wait_cmd(40);
        check("mid_act", 32'(o_cmd), 32'(CMD_ACT));
        #3;
        i_rst = 1'b1;
        #1;
        check("mid_rst_cmd", 32'(o_cmd), 32'(CMD_NOP));
        check("mid_rst_done", 32'(o_init_done), 32'd0);
        check("mid_rst_ba", 32'(o_ba), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check_init();
        wait_cmd(40);
        check("post_rst_act", 32'(o_cmd), 32'(CMD_ACT));
        check("post_rst_ba", 32'(o_ba), 32'd1);
        wait_cmd(20);
        check("post_rst_wr", 32'(o_cmd), 32'(CMD_WRITE));
        check("post_rst_ack", 32'(o_wr_ack), 32'd1);
        i_wr_req = 1'b0;
        repeat (15) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
